// File: rtl/host_cmd_pkg.sv
// Shared definitions for the host command port: header layout, FSM state
// encodings and the byte-count helper for the address/length fields.
package host_cmd_pkg;

  localparam int RW_BIT     = 7;
  localparam int DEST_MSB   = 6;
  localparam int DEST_LSB   = 4;
  localparam int DEST_IDX_W = DEST_MSB - DEST_LSB + 1;

  typedef enum logic [1:0] {
    P_HDR,
    P_ADDR,
    P_LEN,
    P_PUSH
  } parse_state_t;

  typedef enum logic [2:0] {
    I_IDLE,
    I_ISSUE,
    I_WAIT,
    I_ACKREQ,
    I_ACKDRV
  } issue_state_t;

  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/host_cmd_fifo.sv
// Small synchronous FIFO for decoded commands; head is read combinationally.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module host_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/host_cmd_port_v3.sv
// Host command port: parses header/address/length frames into a command FIFO,
// issues one command at a time to the transaction FSM and posts a completion ack.
module host_cmd_port_v3
  import host_cmd_pkg::*;
#(
  parameter int                  DATA_W    = 8,
  parameter int                  ADDR_W    = 24,
  parameter int                  LEN_W     = 9,
  parameter int                  N_DEST    = 3,
  parameter int                  CMD_DEPTH = 2,
  parameter int                  ACK_ID_W  = 2,
  parameter logic [ACK_ID_W-1:0] ACK_ID    = 2'b01
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic                         cmd_r_w,
  output logic [N_DEST-1:0]            cmd_dest,
  output logic [ADDR_W-1:0]            cmd_addr,
  output logic [LEN_W-1:0]             cmd_len,
  input  logic                         txn_done,
  output logic                         ack_req,
  input  logic                         ack_owned,
  output logic                         ack_valid,
  output logic [ACK_ID_W-1:0]          ack_id,
  output logic                         err,
  input  logic                         err_clr,
  output logic [$clog2(CMD_DEPTH):0]   q_count
);

  localparam int A_BYTES = bytes_for(ADDR_W);
  localparam int L_BYTES = bytes_for(LEN_W);
  localparam int MAX_BYTES = (A_BYTES > L_BYTES) ? A_BYTES : L_BYTES;
  localparam int BEAT_W = $clog2(MAX_BYTES + 1);
  localparam int ENT_W = 1 + DEST_IDX_W + ADDR_W + LEN_W;
  localparam logic [BEAT_W-1:0] A_LAST = BEAT_W'(A_BYTES - 1);
  localparam logic [BEAT_W-1:0] L_LAST = BEAT_W'(L_BYTES - 1);
  localparam logic [DEST_IDX_W:0] N_DEST_L = (DEST_IDX_W + 1)'(N_DEST);

  parse_state_t          pstate, pstate_n;
  issue_state_t          istate, istate_n;

  logic                  live;
  logic                  accept;
  logic [BEAT_W-1:0]     beat;
  logic                  hdr_rw;
  logic [DEST_IDX_W-1:0] hdr_dest;
  logic [ADDR_W-1:0]     addr_q;
  logic [LEN_W-1:0]      len_q;
  logic [ADDR_W-1:0]     addr_next;
  logic [LEN_W-1:0]      len_next;
  logic                  frame_bad;
  logic                  frame_bad_now;
  logic                  last_len;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENT_W-1:0]      fifo_wdata;
  logic [ENT_W-1:0]      fifo_rdata;

  logic                  head_rw;
  logic [DEST_IDX_W-1:0] head_dest;
  logic [ADDR_W-1:0]     head_addr;
  logic [LEN_W-1:0]      head_len;

  // live keeps in_ready low while reset is asserted even though the parser sits in HDR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  assign in_ready  = live && (pstate != P_PUSH);
  assign accept    = in_valid && in_ready;
  assign addr_next = ADDR_W'({addr_q, in_data});
  assign len_next  = LEN_W'({len_q, in_data});
  assign last_len  = (pstate == P_LEN) && (beat == L_LAST);
  assign frame_bad_now = ({1'b0, hdr_dest} >= N_DEST_L) || (len_next == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pstate <= P_HDR;
    else     pstate <= pstate_n;
  end

  always_comb begin
    pstate_n = pstate;
    case (pstate)
      P_HDR:   if (accept) pstate_n = P_ADDR;
      P_ADDR:  if (accept && beat == A_LAST) pstate_n = P_LEN;
      P_LEN:   if (accept && beat == L_LAST) pstate_n = P_PUSH;
      P_PUSH:  if (frame_bad || !fifo_full || fifo_pop) pstate_n = P_HDR;
      default: pstate_n = P_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= '0;
      hdr_rw    <= 1'b0;
      hdr_dest  <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      frame_bad <= 1'b0;
    end else if (accept) begin
      case (pstate)
        P_HDR: begin
          hdr_rw   <= in_data[RW_BIT];
          hdr_dest <= in_data[DEST_MSB:DEST_LSB];
          addr_q   <= '0;
          len_q    <= '0;
          beat     <= '0;
        end
        P_ADDR: begin
          addr_q <= addr_next;
          beat   <= (beat == A_LAST) ? '0 : beat + BEAT_W'(1);
        end
        P_LEN: begin
          len_q <= len_next;
          if (beat == L_LAST) begin
            beat      <= '0;
            frame_bad <= frame_bad_now;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // a new error outranks a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     err <= 1'b0;
    else if (accept && last_len && frame_bad_now) err <= 1'b1;
    else if (err_clr)                            err <= 1'b0;
  end

  assign fifo_push  = (pstate == P_PUSH) && !frame_bad;
  assign fifo_wdata = {hdr_rw, hdr_dest, addr_q, len_q};

  host_cmd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

  assign {head_rw, head_dest, head_addr, head_len} = fifo_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) istate <= I_IDLE;
    else     istate <= istate_n;
  end

  always_comb begin
    istate_n  = istate;
    cmd_valid = 1'b0;
    fifo_pop  = 1'b0;
    ack_req   = 1'b0;
    ack_valid = 1'b0;
    ack_id    = '0;
    case (istate)
      I_IDLE:   if (!fifo_empty) istate_n = I_ISSUE;
      I_ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          fifo_pop = 1'b1;
          istate_n = I_WAIT;
        end
      end
      I_WAIT:   if (txn_done) istate_n = I_ACKREQ;
      I_ACKREQ: begin
        ack_req = 1'b1;
        if (ack_owned) istate_n = I_ACKDRV;
      end
      I_ACKDRV: begin
        ack_valid = 1'b1;
        ack_id    = ACK_ID;
        istate_n  = I_IDLE;
      end
      default:  istate_n = I_IDLE;
    endcase
  end

  assign cmd_r_w  = cmd_valid & head_rw;
  assign cmd_dest = cmd_valid ? (N_DEST'(1) << head_dest) : '0;
  assign cmd_addr = cmd_valid ? head_addr : '0;
  assign cmd_len  = cmd_valid ? head_len : '0;

endmodule

// File: tb/tb_host_cmd_port_v3.sv
// Directed bench for host_cmd_port_v3: frame decode, backpressure, errors,
// reset recovery and a seeded gap pattern against hand-built expectations.
module tb_host_cmd_port_v3;

  typedef struct packed {
    logic        rw;
    logic [2:0]  dest;
    logic [23:0] addr;
    logic [8:0]  len;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_r_w;
  logic [2:0]  cmd_dest;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        txn_done;
  logic        ack_req;
  logic        ack_owned;
  logic        ack_valid;
  logic [1:0]  ack_id;
  logic        err;
  logic        err_clr;
  logic [1:0]  q_count;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;
  exp_t exp_q[$];

  host_cmd_port_v3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_r_w   (cmd_r_w),
    .cmd_dest  (cmd_dest),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .txn_done  (txn_done),
    .ack_req   (ack_req),
    .ack_owned (ack_owned),
    .ack_valid (ack_valid),
    .ack_id    (ack_id),
    .err       (err),
    .err_clr   (err_clr),
    .q_count   (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ack_valid) ack_cnt++;

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout in_ready got 0 exp 1 byte=%h", b);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f, input int gap);
    for (int i = 0; i < 6; i++)
      send_byte(f[47-8*i -: 8], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
  endtask

  task automatic serve(input exp_t e, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s cmd_valid_timeout got %b exp 1", name, cmd_valid);
      return;
    end
    checks++;
    if (cmd_r_w !== e.rw) begin failures++; $display("FAIL %s cmd_r_w got %b exp %b", name, cmd_r_w, e.rw); end
    checks++;
    if (cmd_dest !== e.dest) begin failures++; $display("FAIL %s cmd_dest got %b exp %b", name, cmd_dest, e.dest); end
    checks++;
    if (cmd_addr !== e.addr) begin failures++; $display("FAIL %s cmd_addr got %h exp %h", name, cmd_addr, e.addr); end
    checks++;
    if (cmd_len !== e.len) begin failures++; $display("FAIL %s cmd_len got %h exp %h", name, cmd_len, e.len); end
    cmd_ready = 1'b1;
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_dest !== 3'b000 || ack_req !== 1'b0) begin
      failures++;
      $display("FAIL %s after_accept valid=%b dest=%b ack_req=%b exp 0 000 0", name, cmd_valid, cmd_dest, ack_req);
    end
    @(negedge clk) txn_done = 1'b1;
    @(posedge clk);
    #1 txn_done = 1'b0;
    checks++;
    if (ack_req !== 1'b1 || ack_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s ack_req_rise ack_req=%b ack_valid=%b exp 1 0", name, ack_req, ack_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ack_req !== 1'b1) begin failures++; $display("FAIL %s ack_req_hold got %b exp 1", name, ack_req); end
    @(negedge clk) ack_owned = 1'b1;
    @(posedge clk);
    #1 ack_owned = 1'b0;
    checks++;
    if (ack_valid !== 1'b1 || ack_id !== 2'b01 || ack_req !== 1'b0) begin
      failures++;
      $display("FAIL %s ack_drive valid=%b id=%b req=%b exp 1 01 0", name, ack_valid, ack_id, ack_req);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ack_valid !== 1'b0 || ack_id !== 2'b00) begin
      failures++;
      $display("FAIL %s ack_one_cycle valid=%b id=%b exp 0 00", name, ack_valid, ack_id);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (in_ready !== 1'b0 || cmd_valid !== 1'b0 || cmd_r_w !== 1'b0 || cmd_dest !== 3'b0 ||
        cmd_addr !== 24'h0 || cmd_len !== 9'h0 || ack_req !== 1'b0 || ack_valid !== 1'b0 ||
        ack_id !== 2'b0 || err !== 1'b0 || q_count !== 2'd0) begin
      failures++;
      $display("FAIL %s outputs rdy=%b cv=%b rw=%b dest=%b addr=%h len=%h req=%b av=%b id=%b err=%b q=%0d exp all 0",
               name, in_ready, cmd_valid, cmd_r_w, cmd_dest, cmd_addr, cmd_len, ack_req, ack_valid, ack_id, err, q_count);
    end
  endtask

  task automatic test_reset();
    #3;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_write_qspi();
    send_frame(48'h10_123456_0020, 0);
    checks++;
    if (cmd_valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL wr_latency0 cmd_valid=%b err=%b exp 0 0", cmd_valid, err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || q_count !== 2'd1) begin
      failures++;
      $display("FAIL wr_latency1 cmd_valid=%b q_count=%0d exp 0 1", cmd_valid, q_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cmd_valid !== 1'b1) begin failures++; $display("FAIL wr_latency2 cmd_valid got %b exp 1", cmd_valid); end
    serve('{rw: 1'b0, dest: 3'b010, addr: 24'h123456, len: 9'h020}, "wr_qspi");
  endtask

  task automatic test_read_fsm();
    send_frame(48'h80_FFFFFF_01FF, 0);
    serve('{rw: 1'b1, dest: 3'b001, addr: 24'hFFFFFF, len: 9'h1FF}, "rd_fsm");
  endtask

  task automatic test_back_to_back();
    cmd_ready = 1'b0;
    send_frame(48'h20_AABBCC_0001, 0);
    send_frame(48'h9F_000000_0100, 0);
    send_frame(48'h05_120034_0080, 0);
    @(posedge clk);
    #1;
    checks++;
    if (q_count !== 2'd2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full q_count=%0d in_ready=%b exp 2 0", q_count, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || cmd_dest !== 3'b100) begin
      failures++;
      $display("FAIL b2b_stall in_ready=%b cmd_dest=%b exp 0 100", in_ready, cmd_dest);
    end
    serve('{rw: 1'b0, dest: 3'b100, addr: 24'hAABBCC, len: 9'h001}, "b2b_a");
    checks++;
    if (q_count !== 2'd2 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_swap q_count=%0d in_ready=%b exp 2 1", q_count, in_ready);
    end
    serve('{rw: 1'b1, dest: 3'b010, addr: 24'h000000, len: 9'h100}, "b2b_b");
    serve('{rw: 1'b0, dest: 3'b001, addr: 24'h120034, len: 9'h080}, "b2b_c");
    checks++;
    if (q_count !== 2'd0) begin failures++; $display("FAIL b2b_drain q_count got %0d exp 0", q_count); end
  endtask

  task automatic test_errors();
    logic seen;
    seen = 1'b0;
    send_frame(48'h30_010203_0005, 0);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_dest err got %b exp 1", err); end
    repeat (3) begin
      @(posedge clk);
      #1 if (cmd_valid !== 1'b0 || q_count !== 2'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL err_dest_nopush cmd_valid/q_count got activity exp none"); end
    @(negedge clk) err_clr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clr1 err got %b exp 0", err); end
    send_frame(48'h00_112233_FE00, 0);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_len0_vs_clr err got %b exp 1", err); end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 if (cmd_valid !== 1'b0 || q_count !== 2'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL err_len0_nopush cmd_valid/q_count got activity exp none"); end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_sticky err got %b exp 1", err); end
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clr2 err got %b exp 0", err); end
  endtask

  task automatic test_reset_mid();
    int n;
    int acks0;
    logic seen;
    send_byte(8'h10, 0);
    send_byte(8'h12, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h34;
    rst      = 1'b1;
    #1 check_zero_outputs("rst_addr2");
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    send_frame(48'hA0_ABCDEF_0033, 0);
    serve('{rw: 1'b1, dest: 3'b100, addr: 24'hABCDEF, len: 9'h033}, "rst_after_addr");

    send_frame(48'h10_000001_0001, 0);
    send_frame(48'h10_000002_0002, 0);
    n = 0;
    @(negedge clk);
    while (!cmd_valid && n < 50) begin @(negedge clk); n++; end
    cmd_ready = 1'b1;
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    checks++;
    if (q_count !== 2'd1) begin failures++; $display("FAIL rst_wait_setup q_count got %0d exp 1", q_count); end
    acks0 = ack_cnt;
    @(negedge clk) rst = 1'b1;
    #1 check_zero_outputs("rst_wait");
    @(negedge clk) rst = 1'b0;
    @(negedge clk) txn_done = 1'b1;
    @(negedge clk) txn_done = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack_req !== 1'b0 || cmd_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || ack_cnt != acks0) begin
      failures++;
      $display("FAIL rst_wait_stale activity=%b acks=%0d exp 0 %0d", seen, ack_cnt, acks0);
    end
    send_frame(48'h90_C0FFEE_0107, 0);
    serve('{rw: 1'b1, dest: 3'b010, addr: 24'hC0FFEE, len: 9'h107}, "rst_after_wait");
  endtask

  task automatic test_random_gaps();
    int acks0;
    logic seen;
    @(negedge clk) txn_done = 1'b1;
    @(negedge clk) txn_done = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack_req !== 1'b0 || ack_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL stray_txn_done ack activity got 1 exp 0"); end
    acks0 = ack_cnt;
    void'($urandom(1));
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          exp_t e;
          logic [2:0]  di;
          logic [6:0]  junk;
          logic [3:0]  rsv;
          logic [47:0] f;
          e.rw   = 1'($urandom_range(0, 1));
          di     = 3'($urandom_range(0, 2));
          e.dest = 3'b001 << di;
          e.addr = 24'($urandom);
          e.len  = 9'($urandom_range(1, 511));
          junk   = 7'($urandom);
          rsv    = 4'($urandom);
          f      = {e.rw, di, rsv, e.addr, junk, e.len};
          exp_q.push_back(e);
          send_frame(f, -1);
        end
      end
      begin
        for (int j = 0; j < 20; j++) begin
          int w;
          w = 0;
          while (exp_q.size() == 0 && w < 200) begin @(negedge clk); w++; end
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rand_queue_timeout size got 0 exp >0");
            break;
          end
          serve(exp_q.pop_front(), "rand");
        end
      end
    join
    repeat (3) @(negedge clk);
    checks++;
    if (ack_cnt != acks0 + 20) begin failures++; $display("FAIL rand_ack_count got %0d exp %0d", ack_cnt - acks0, 20); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    cmd_ready = 1'b0;
    txn_done  = 1'b0;
    ack_owned = 1'b0;
    err_clr   = 1'b0;
    test_reset();
    test_write_qspi();
    test_read_fsm();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_random_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time limit reached exp finish");
    $fatal(1);
  end

endmodule
